// File: rtl/inst_issue_ctrl.sv
// Fetch/issue sequencer for the vector-DLP decoder: prefetch queue, fused
// M_VLOAD+VMAC pair issue, RAW-hazard bubbles against a 2-deep writeback scoreboard.
//
//   state   | meaning
//   S_IDLE  | waiting for Start_i
//   S_RUN   | fetching Start_pc_i..End_pc_i while issuing
//   S_DRAIN | all reads requested; emptying queue, reads and scoreboard
//   S_DONE  | one-cycle completion pulse on Done_o
module inst_issue_ctrl #(
  parameter int ISAW   = 16,
  parameter int OPW    = 3,
  parameter int PCW    = 8,
  parameter int VREGAW = 3,
  parameter int QDEPTH = 4,
  parameter logic [ISAW-1:0] NOP_INST = 16'hA000
) (
  input  logic            Clk_i,
  input  logic            Rst_n_i,
  input  logic            Start_i,
  input  logic [PCW-1:0]  Start_pc_i,
  input  logic [PCW-1:0]  End_pc_i,
  output logic            Icm_ren_o,
  output logic [PCW-1:0]  Icm_addr_o,
  input  logic [ISAW-1:0] Icm_rdata_i,
  output logic [ISAW-1:0] Inst_c_o,
  output logic [ISAW-1:0] Inst_n_o,
  output logic            Busy_o,
  output logic            Done_o,
  output logic [15:0]     Stall_cnt_o
);

  localparam int QAW  = $clog2(QDEPTH);
  localparam int CNTW = QAW + 1;
  localparam logic [CNTW:0]   QDEPTH_L = (CNTW+1)'(QDEPTH);
  localparam logic [CNTW-1:0] CNT_TWO  = CNTW'(2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [PCW-1:0]        r_pc;
  logic [ISAW-1:0]       r_q [QDEPTH];
  logic [QAW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_inflight;
  logic                  r_stg_v;
  logic [ISAW-1:0]       r_stg;
  logic [1:0]            r_sb_v;
  logic [VREGAW-1:0]     r_sb_rd0, r_sb_rd1;
  logic [15:0]           r_stall_cnt;

  logic                  w_ren, w_start_acc, w_fetch_done, w_has2, w_pair, w_hit;
  logic [CNTW:0]         w_occ;
  logic [QAW-1:0]        w_rd_ptr_n;
  logic [ISAW-1:0]       w_head, w_next, w_inst_c, w_inst_n;
  logic [OPW-1:0]        w_op_h, w_op_n;
  logic [3:0]            w_fn_h, w_fn_n;
  logic [1:0]            w_src_v;
  logic [VREGAW-1:0]     w_src0, w_src1, w_wr_rd;
  logic                  w_hazard, w_wr_v;
  logic [CNTW-1:0]       w_pop_n;

  function automatic logic f_match(input logic [VREGAW-1:0] src, input logic [1:0] sb_v,
                                   input logic [VREGAW-1:0] rd0, input logic [VREGAW-1:0] rd1);
    return (sb_v[0] && (rd0 == src)) || (sb_v[1] && (rd1 == src));
  endfunction

  assign w_occ        = {1'b0, r_cnt} + (CNTW+1)'(r_inflight) + (CNTW+1)'(r_stg_v);
  assign w_ren        = (r_state == S_RUN) && (r_pc <= End_pc_i) && (w_occ < QDEPTH_L);
  assign w_start_acc  = (r_state == S_IDLE) && Start_i;
  // Partner of a lone M_VLOAD can still arrive until every read has landed.
  assign w_fetch_done = (r_state != S_RUN) && !r_inflight && !r_stg_v;
  assign w_has2       = (r_cnt >= CNT_TWO);
  assign w_rd_ptr_n   = r_rd_ptr + QAW'(1);
  assign w_head       = r_q[r_rd_ptr];
  assign w_next       = r_q[w_rd_ptr_n];
  assign w_op_h       = w_head[ISAW-1:ISAW-OPW];
  assign w_op_n       = w_next[ISAW-1:ISAW-OPW];
  assign w_fn_h       = w_head[3:0];
  assign w_fn_n       = w_next[3:0];
  assign w_pair       = (w_op_h == 3'b011) && w_has2 && (w_op_n == 3'b110) && (w_fn_n == 4'b1000);

  always_comb begin
    w_src_v = 2'b00;
    w_src0  = '0;
    w_src1  = '0;
    if (w_pair) begin
      w_src_v = 2'b01;
      w_src0  = w_next[9:7];
    end else begin
      case (w_op_h)
        3'b100: begin
          w_src_v = 2'b01;
          w_src0  = w_head[3:1];
        end
        3'b110: begin
          if (w_fn_h inside {4'b0000, 4'b0001, 4'b0010, 4'b0111, 4'b1111}) begin
            w_src_v = 2'b11;
            w_src0  = w_head[9:7];
            w_src1  = w_head[6:4];
          end else if (w_fn_h == 4'b1000) begin
            w_src_v = 2'b01;
            w_src0  = w_head[9:7];
          end
        end
        default: ;
      endcase
    end
    w_hit = (w_src_v[0] && f_match(w_src0, r_sb_v, r_sb_rd0, r_sb_rd1)) ||
            (w_src_v[1] && f_match(w_src1, r_sb_v, r_sb_rd0, r_sb_rd1));
  end

  always_comb begin
    w_inst_c = NOP_INST;
    w_inst_n = NOP_INST;
    w_pop_n  = '0;
    w_hazard = 1'b0;
    w_wr_v   = 1'b0;
    w_wr_rd  = '0;
    if (r_cnt != '0) begin
      if (w_hit) begin
        w_hazard = 1'b1;
      end else if (w_pair) begin
        w_inst_c = w_head;
        w_inst_n = w_next;
        w_pop_n  = CNTW'(2);
        w_wr_v   = 1'b1;
        w_wr_rd  = w_head[12:10];
      end else if ((w_op_h == 3'b011) && !w_has2 && !w_fetch_done) begin
        w_pop_n  = '0;
      end else begin
        w_inst_c = w_head;
        if (w_has2) w_inst_n = w_next;
        w_pop_n  = CNTW'(1);
        w_wr_v   = (w_op_h == 3'b010) || (w_op_h == 3'b011) ||
                   ((w_op_h == 3'b110) && ((w_fn_h == 4'b0111) || (w_fn_h == 4'b1111)));
        w_wr_rd  = w_head[12:10];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start_i) w_state_nxt = S_RUN;
      S_RUN:   if ((r_pc > End_pc_i) || (w_ren && (r_pc == End_pc_i))) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_cnt == '0) && !r_inflight && !r_stg_v && (r_sb_v == 2'b00))
                 w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_stg_v     <= 1'b0;
      r_stg       <= '0;
      r_sb_v      <= 2'b00;
      r_sb_rd0    <= '0;
      r_sb_rd1    <= '0;
      r_stall_cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc)  r_pc <= Start_pc_i;
      else if (w_ren)   r_pc <= r_pc + PCW'(1);
      // Read data is staged one cycle before it enters the queue.
      r_inflight <= w_ren;
      r_stg_v    <= r_inflight;
      if (r_inflight) r_stg <= Icm_rdata_i;
      if (r_stg_v) begin
        r_q[r_wr_ptr] <= r_stg;
        r_wr_ptr      <= r_wr_ptr + QAW'(1);
      end
      r_rd_ptr <= r_rd_ptr + w_pop_n[QAW-1:0];
      r_cnt    <= r_cnt + CNTW'(r_stg_v) - w_pop_n;
      r_sb_v   <= {r_sb_v[0], w_wr_v};
      r_sb_rd0 <= w_wr_rd;
      r_sb_rd1 <= r_sb_rd0;
      if (w_start_acc)                         r_stall_cnt <= '0;
      else if (w_hazard && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign Icm_ren_o   = w_ren;
  assign Icm_addr_o  = r_pc;
  assign Inst_c_o    = w_inst_c;
  assign Inst_n_o    = w_inst_n;
  assign Busy_o      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign Done_o      = (r_state == S_DONE);
  assign Stall_cnt_o = r_stall_cnt;

endmodule
